// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : shared 7-segment constants, anode codes and capture FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_D3   = 2'd1,
    ST_D2   = 2'd2,
    ST_D1   = 2'd3
  } state_t;

  // Anode codes are one-cold; 1111 is the blanking interval between slots
  localparam logic [3:0] c_anode_blank = 4'b1111;
  localparam logic [3:0] c_anode_d3    = 4'b0111;
  localparam logic [3:0] c_anode_d2    = 4'b1011;
  localparam logic [3:0] c_anode_d1    = 4'b1101;
  localparam logic [3:0] c_anode_d0    = 4'b1110;

  // Active-low segment patterns, bit6=a ... bit0=g
  localparam logic [6:0] c_seg_0   = 7'b0000001;
  localparam logic [6:0] c_seg_1   = 7'b1001111;
  localparam logic [6:0] c_seg_2   = 7'b0010010;
  localparam logic [6:0] c_seg_3   = 7'b0000110;
  localparam logic [6:0] c_seg_4   = 7'b1001100;
  localparam logic [6:0] c_seg_5   = 7'b0100100;
  localparam logic [6:0] c_seg_6   = 7'b0100000;
  localparam logic [6:0] c_seg_7   = 7'b0001111;
  localparam logic [6:0] c_seg_8   = 7'b0000000;
  localparam logic [6:0] c_seg_9   = 7'b0000100;
  localparam logic [6:0] c_seg_off = 7'b1111111;

  localparam int unsigned c_settle_cycles_default  = 16;
  localparam int unsigned c_timeout_cycles_default = 1048576;

  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100 +
           14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ============================================================================
// seg7_pattern_decode : active-low segment pattern -> {legal, bcd}
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] bcd
);

  always_comb begin
    legal = 1'b1;
    bcd   = 4'd0;
    case (pattern)
      c_seg_0: bcd = 4'd0;
      c_seg_1: bcd = 4'd1;
      c_seg_2: bcd = 4'd2;
      c_seg_3: bcd = 4'd3;
      c_seg_4: bcd = 4'd4;
      c_seg_5: bcd = 4'd5;
      c_seg_6: bcd = 4'd6;
      c_seg_7: bcd = 4'd7;
      c_seg_8: bcd = 4'd8;
      c_seg_9: bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_capture.sv
// ============================================================================
// seg7_scan_capture : samples a scanned 4-digit 7-segment bus and rebuilds frames
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = c_settle_cycles_default,
  parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles_default
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] digits_out,
  output logic [13:0] value_out,
  output logic        frame_valid,
  output logic        seg_error,
  output logic        frame_error,
  output logic        stall
);

  localparam int unsigned c_settle_w  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned c_timeout_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_settle_w-1:0]  c_settle_max  = c_settle_w'(SETTLE_CYCLES);
  localparam logic [c_timeout_w-1:0] c_timeout_max = c_timeout_w'(TIMEOUT_CYCLES);
  localparam logic [c_timeout_w-1:0] c_timeout_end = c_timeout_w'(TIMEOUT_CYCLES - 1);

  logic [3:0]             r_anode_s1, r_anode_s2;
  logic [6:0]             r_seg_s1, r_seg_s2;
  logic [c_settle_w-1:0]  r_stable;
  logic [c_timeout_w-1:0] r_timeout;
  logic                   r_captured;
  state_t                 r_state;
  logic                   r_bad;
  logic [3:0]             r_d3, r_d2, r_d1;

  logic       w_change, w_anode_change, w_sample, w_timeout_hit;
  logic       w_one_cold, w_legal;
  logic [3:0] w_bcd, w_expected;

  // Comparing the two synchroniser stages flags a change one cycle early,
  // so the counters restart on the same edge the new value lands in stage 2.
  assign w_anode_change = (r_anode_s1 != r_anode_s2);
  assign w_change       = w_anode_change || (r_seg_s1 != r_seg_s2);
  assign w_sample       = (r_stable == c_settle_max) && !r_captured;
  assign w_timeout_hit  = (r_timeout == c_timeout_end) && !w_anode_change;
  assign w_one_cold     = (r_anode_s2 == c_anode_d3) || (r_anode_s2 == c_anode_d2) ||
                          (r_anode_s2 == c_anode_d1) || (r_anode_s2 == c_anode_d0);

  seg7_pattern_decode u_decode (
    .pattern (r_seg_s2),
    .legal   (w_legal),
    .bcd     (w_bcd)
  );

  always_comb begin
    w_expected = c_anode_d3;
    case (r_state)
      ST_D3:   w_expected = c_anode_d2;
      ST_D2:   w_expected = c_anode_d1;
      ST_D1:   w_expected = c_anode_d0;
      default: w_expected = c_anode_d3;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_anode_s1 <= c_anode_blank;
      r_anode_s2 <= c_anode_blank;
      r_seg_s1   <= c_seg_off;
      r_seg_s2   <= c_seg_off;
      r_stable   <= '0;
      r_captured <= 1'b0;
      r_timeout  <= '0;
      stall      <= 1'b0;
    end else begin
      r_anode_s1 <= anode_in;
      r_anode_s2 <= r_anode_s1;
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;

      if (w_change)
        r_stable <= '0;
      else if (r_stable != c_settle_max)
        r_stable <= r_stable + c_settle_w'(1);

      if (w_anode_change)
        r_captured <= 1'b0;
      else if (w_sample)
        r_captured <= 1'b1;

      if (w_anode_change) begin
        r_timeout <= '0;
        stall     <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timeout <= c_timeout_max;
        stall     <= 1'b1;
      end else if (r_timeout != c_timeout_max) begin
        r_timeout <= r_timeout + c_timeout_w'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bad       <= 1'b0;
      r_d3        <= 4'd0;
      r_d2        <= 4'd0;
      r_d1        <= 4'd0;
      digits_out  <= 16'd0;
      value_out   <= 14'd0;
      frame_valid <= 1'b0;
      seg_error   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      seg_error   <= 1'b0;
      frame_error <= 1'b0;

      if (w_sample && (r_anode_s2 != c_anode_blank)) begin
        seg_error <= !w_legal;
        if (!w_one_cold) begin
          frame_error <= 1'b1;
          r_state     <= ST_IDLE;
        end else if (r_state == ST_IDLE || r_anode_s2 != w_expected) begin
          // A thousands slot always (re)starts a frame; anything else out of order aborts it
          if (r_state != ST_IDLE)
            frame_error <= 1'b1;
          if (r_anode_s2 == c_anode_d3) begin
            r_state <= ST_D3;
            r_bad   <= !w_legal;
            r_d3    <= w_bcd;
          end else begin
            r_state <= ST_IDLE;
          end
        end else begin
          r_bad <= r_bad || !w_legal;
          case (r_state)
            ST_D3: begin
              r_d2    <= w_bcd;
              r_state <= ST_D2;
            end
            ST_D2: begin
              r_d1    <= w_bcd;
              r_state <= ST_D1;
            end
            default: begin
              if (!r_bad && w_legal) begin
                digits_out  <= {r_d3, r_d2, r_d1, w_bcd};
                value_out   <= bcd_to_bin({r_d3, r_d2, r_d1, w_bcd});
                frame_valid <= 1'b1;
              end
              r_state <= ST_IDLE;
            end
          endcase
        end
      end

      if (w_timeout_hit)
        r_state <= ST_IDLE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
// ============================================================================
// tb_seg7_scan_capture : scoreboard bench driving scanned display frames
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_scan_capture;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 2000;
  localparam int SLOT    = 64;

  logic        clk_100MHz = 1'b0;
  logic        reset_n    = 1'b0;
  logic [3:0]  anode_in   = 4'b1111;
  logic [6:0]  seg_in     = 7'b1111111;
  logic [15:0] digits_out;
  logic [13:0] value_out;
  logic        frame_valid, seg_error, frame_error, stall;

  seg7_scan_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .anode_in    (anode_in),
    .seg_in      (seg_in),
    .digits_out  (digits_out),
    .value_out   (value_out),
    .frame_valid (frame_valid),
    .seg_error   (seg_error),
    .frame_error (frame_error),
    .stall       (stall)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_valid   = 0;
  int n_seg_err = 0;
  int n_frm_err = 0;
  logic [15:0] sb_q[$];
  logic [15:0] exp_bcd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [31:0] bin_of(input logic [15:0] b);
    return 32'(b[15:12]) * 1000 + 32'(b[11:8]) * 100 + 32'(b[7:4]) * 10 + 32'(b[3:0]);
  endfunction

  task automatic slot(input logic [3:0] an, input logic [6:0] sg, input int cyc);
    anode_in = an;
    seg_in   = sg;
    repeat (cyc) @(negedge clk_100MHz);
  endtask

  task automatic frame(input logic [15:0] bcd, input bit pub);
    slot(4'b0111, seg_of(bcd[15:12]), SLOT);
    slot(4'b1011, seg_of(bcd[11:8]), SLOT);
    slot(4'b1101, seg_of(bcd[7:4]), SLOT);
    if (pub) sb_q.push_back(bcd);
    slot(4'b1110, seg_of(bcd[3:0]), SLOT);
  endtask

  // Output side of the scoreboard: every publish must match the oldest expected frame
  always @(negedge clk_100MHz) begin
    if (seg_error)   n_seg_err++;
    if (frame_error) n_frm_err++;
    if (frame_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        chk("unexpected_publish", 32'(digits_out), 32'hFFFF_FFFF);
      end else begin
        exp_bcd = sb_q.pop_front();
        chk("digits", 32'(digits_out), 32'(exp_bcd));
        chk("value", 32'(value_out), bin_of(exp_bcd));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, s0, f0;
    repeat (3) @(negedge clk_100MHz);
    chk("rst_digits", 32'(digits_out), 32'd0);
    chk("rst_value", 32'(value_out), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_seg_err", 32'(seg_error), 32'd0);
    chk("rst_frm_err", 32'(frame_error), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_100MHz);

    // Plain scan of 1234, twice
    v0 = n_valid;
    frame(16'h1234, 1'b1);
    frame(16'h1234, 1'b1);
    chk("t1_pubs", 32'(n_valid - v0), 32'd2);

    // Glitch in the tens slot: "8" briefly, then settles on "3"
    v0 = n_valid; s0 = n_seg_err;
    slot(4'b0111, seg_of(4'd5), SLOT);
    slot(4'b1011, seg_of(4'd6), SLOT);
    slot(4'b1101, seg_of(4'd8), 5);
    slot(4'b1101, seg_of(4'd3), SLOT - 5);
    sb_q.push_back(16'h5637);
    slot(4'b1110, seg_of(4'd7), SLOT);
    chk("t2_pubs", 32'(n_valid - v0), 32'd1);
    chk("t2_seg_err", 32'(n_seg_err - s0), 32'd0);

    // Illegal pattern in the hundreds slot spoils that frame only
    v0 = n_valid; s0 = n_seg_err;
    slot(4'b0111, seg_of(4'd9), SLOT);
    slot(4'b1011, 7'b1111111, SLOT);
    slot(4'b1101, seg_of(4'd1), SLOT);
    slot(4'b1110, seg_of(4'd2), SLOT);
    chk("t3_seg_err", 32'(n_seg_err - s0), 32'd1);
    chk("t3_no_pub", 32'(n_valid - v0), 32'd0);
    frame(16'h4321, 1'b1);
    chk("t3_next_pub", 32'(n_valid - v0), 32'd1);

    // Out-of-order slot, then a non one-cold anode
    v0 = n_valid; f0 = n_frm_err;
    slot(4'b0111, seg_of(4'd1), SLOT);
    slot(4'b1101, seg_of(4'd2), SLOT);
    slot(4'b1110, seg_of(4'd3), SLOT);
    chk("t4_order_err", 32'(n_frm_err - f0), 32'd1);
    chk("t4_no_pub", 32'(n_valid - v0), 32'd0);
    slot(4'b0011, seg_of(4'd4), SLOT);
    chk("t4_anode_err", 32'(n_frm_err - f0), 32'd2);
    frame(16'h2468, 1'b1);
    chk("t4_resync_pub", 32'(n_valid - v0), 32'd1);
    chk("t4_err_total", 32'(n_frm_err - f0), 32'd2);

    // Stall: hundreds slot frozen past the timeout aborts the partial frame
    v0 = n_valid;
    slot(4'b0111, seg_of(4'd1), SLOT);
    slot(4'b1011, seg_of(4'd2), TIMEOUT - 20);
    chk("t5_no_stall_yet", 32'(stall), 32'd0);
    repeat (40) @(negedge clk_100MHz);
    chk("t5_stall", 32'(stall), 32'd1);
    slot(4'b1101, seg_of(4'd3), 4);
    chk("t5_stall_clear", 32'(stall), 32'd0);
    slot(4'b1101, seg_of(4'd3), SLOT - 4);
    slot(4'b1110, seg_of(4'd4), SLOT);
    chk("t5_aborted", 32'(n_valid - v0), 32'd0);
    frame(16'h8765, 1'b1);
    chk("t5_resync_pub", 32'(n_valid - v0), 32'd1);
    chk("t5_stall_low", 32'(stall), 32'd0);

    // Reset in the tens slot of 0042
    v0 = n_valid;
    slot(4'b0111, seg_of(4'd0), SLOT);
    slot(4'b1011, seg_of(4'd0), SLOT);
    slot(4'b1101, seg_of(4'd4), 30);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_digits", 32'(digits_out), 32'd0);
    chk("t6_rst_value", 32'(value_out), 32'd0);
    repeat (3) @(negedge clk_100MHz);
    reset_n = 1'b1;
    slot(4'b1101, seg_of(4'd4), 30);
    slot(4'b1110, seg_of(4'd2), SLOT);
    chk("t6_partial_dropped", 32'(n_valid - v0), 32'd0);
    frame(16'h0042, 1'b1);
    frame(16'h9999, 1'b1);
    frame(16'h0000, 1'b1);
    chk("t6_pubs", 32'(n_valid - v0), 32'd3);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
